// File: rtl/aes_pkg.sv
`default_nettype none
// =====================================================================
// aes_pkg : AES-128 types, round constants and byte-level helpers
// Rev 1.0
// =====================================================================
package aes_pkg;

    localparam int NR = 10;

    typedef logic [31:0] word_t;
    // [column][row]; byte 0 of the block sits at [0][0] (MSB end)
    typedef logic [0:3][0:3][7:0] state_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_INIT   = 3'd2,
        S_ROUNDS = 3'd3,
        S_DONE   = 3'd4
    } fsm_e;

    // Index i holds Rcon(i); unused slots are zero so any 4-bit index is safe
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [0:255][7:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_T[x];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_T[x];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (enough for 9, 11, 13, 14)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] x1, x2, x3;
        x1 = xtime(a);
        x2 = xtime(x1);
        x3 = xtime(x2);
        return ({8{m[0]}} & a) ^ ({8{m[1]}} & x1) ^ ({8{m[2]}} & x2) ^ ({8{m[3]}} & x3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// =====================================================================
// aes_key_step : one AES-128 key-schedule step, forward (dir_i=0)
//                or inverse (dir_i=1), purely combinational
// Rev 1.0
// =====================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  logic         dir_i,
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] rk_o
);

    word_t w0, w1, w2, w3, u3, t, n0, n1, n2, n3;

    always_comb begin
        w0 = rk_i[127:96];
        w1 = rk_i[95:64];
        w2 = rk_i[63:32];
        w3 = rk_i[31:0];
        // Inverse direction needs the previous w3, recovered as n3 ^ n2
        u3 = dir_i ? (w3 ^ w2) : w3;
        t  = sub_word({u3[23:0], u3[31:24]}) ^ {rcon_i, 24'h000000};
        if (dir_i) begin
            n0 = w0 ^ t;
            n1 = w1 ^ w0;
            n2 = w2 ^ w1;
            n3 = w3 ^ w2;
        end else begin
            n0 = w0 ^ t;
            n1 = w1 ^ n0;
            n2 = w2 ^ n1;
            n3 = w3 ^ n2;
        end
        rk_o = {n0, n1, n2, n3};
    end

endmodule
`default_nettype wire

// File: rtl/invaes.sv
`default_nettype none
// =====================================================================
// invaes : iterative AES-128 decryptor behind a load-framed serial link.
//          Build option INVAES_KEYSTORE_EN keeps all 11 round keys.
// Rev 1.0
// =====================================================================
module invaes
    import aes_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic sdi,
    input  logic load,
    output logic sdo,
    output logic done
);

    logic [255:0] in_q;
    logic [7:0]   pos_q, pos_n_q;
    logic         load_s1_q, load_s2_q, load_p_q;
    fsm_e         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d, key_q, key_d;
    logic         done_q, done_d;
    logic         w_start, w_dir;
    logic [3:0]   w_rcon_idx;
    logic [127:0] w_step, w_rk;
    wire state_t  w_blk, w_isb, w_ark, w_imc;

    // ---------------- serial clock domain ----------------
    always_ff @(posedge sck or negedge reset) begin
        if (!reset) begin
            in_q <= '0;
        end else if (load) begin
            in_q <= {in_q[254:0], sdi};
        end
    end

    // Read pointer: counts sck pulses while done, saturating at 128
    always_ff @(posedge sck or negedge reset) begin
        if (!reset) begin
            pos_q <= '0;
        end else if (!done_q) begin
            pos_q <= '0;
        end else if (!pos_q[7]) begin
            pos_q <= pos_q + 8'd1;
        end
    end

    always_ff @(negedge sck or negedge reset) begin
        if (!reset) begin
            pos_n_q <= '0;
        end else begin
            pos_n_q <= pos_q;
        end
    end

    assign sdo  = done_q & ~pos_n_q[7] & blk_q[~pos_n_q[6:0]];
    assign done = done_q;

    // ---------------- core clock domain ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_s1_q <= 1'b0;
            load_s2_q <= 1'b0;
            load_p_q  <= 1'b0;
            fsm_q     <= S_IDLE;
            cnt_q     <= '0;
            blk_q     <= '0;
            key_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            load_s1_q <= load;
            load_s2_q <= load_s1_q;
            load_p_q  <= load_s2_q;
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            blk_q     <= blk_d;
            key_q     <= key_d;
            done_q    <= done_d;
        end
    end

    assign w_start = load_p_q & ~load_s2_q;

`ifdef INVAES_KEYSTORE_EN
    logic [127:0] rk_q [0:NR];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else if ((fsm_q == S_IDLE) && w_start) begin
            rk_q[0] <= in_q[127:0];
        end else if (fsm_q == S_KEYEXP) begin
            rk_q[cnt_q] <= w_step;
        end
    end

    assign w_dir      = 1'b0;
    assign w_rcon_idx = cnt_q;
    assign w_rk       = rk_q[cnt_q];
`else
    // In ROUNDS the step undoes round cnt_q+1 to yield rk_(cnt_q)
    assign w_dir      = (fsm_q == S_ROUNDS);
    assign w_rcon_idx = (fsm_q == S_ROUNDS) ? (cnt_q + 4'd1) : cnt_q;
    assign w_rk       = w_step;
`endif

    aes_key_step u_key_step (
        .dir_i  (w_dir),
        .rk_i   (key_q),
        .rcon_i (RCON[w_rcon_idx]),
        .rk_o   (w_step)
    );

    // Inverse round: InvShiftRows + InvSubBytes, AddRoundKey, InvMixColumns
    assign w_blk = blk_q;
    assign w_ark = w_isb ^ w_rk;

    generate
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                assign w_isb[c][r] = inv_sbox(w_blk[(c + 4 - r) % 4][r]);
                assign w_imc[c][r] = gmul(w_ark[c][r],           4'd14)
                                   ^ gmul(w_ark[c][(r + 1) % 4], 4'd11)
                                   ^ gmul(w_ark[c][(r + 2) % 4], 4'd13)
                                   ^ gmul(w_ark[c][(r + 3) % 4], 4'd9);
            end
        end
    endgenerate

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        blk_d  = blk_q;
        key_d  = key_q;
        done_d = (fsm_q == S_DONE) && !load_s2_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (w_start) begin
                    fsm_d = S_KEYEXP;
                    cnt_d = 4'd1;
                    blk_d = in_q[255:128];
                    key_d = in_q[127:0];
                end
            end
            S_KEYEXP: begin
                key_d = w_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(NR)) begin
                    fsm_d = S_INIT;
                end
            end
            S_INIT: begin
                blk_d = blk_q ^ key_q;
                cnt_d = 4'(NR - 1);
                fsm_d = S_ROUNDS;
            end
            S_ROUNDS: begin
                blk_d = (cnt_q == 4'd0) ? w_ark : w_imc;
                key_d = w_rk;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                if (load_s2_q) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
        if (load_s2_q && (fsm_q inside {S_KEYEXP, S_INIT, S_ROUNDS})) begin
            fsm_d = S_IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_invaes.sv
`default_nettype none
// =====================================================================
// tb_invaes : directed vector bench for the invaes decryptor
// Rev 1.0
// =====================================================================
module tb_invaes;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           extra;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic sck   = 1'b0;
    logic sdi   = 1'b0;
    logic load  = 1'b0;
    logic sdo;
    logic done;

    int total = 0;
    int bad   = 0;

    vec_t vecs [4];

    invaes dut (
        .clk   (clk),
        .reset (reset),
        .sck   (sck),
        .sdi   (sdi),
        .load  (load),
        .sdo   (sdo),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic sck_pulse(input logic b);
        sdi = b;
        #3 sck = 1'b1;
        #4 sck = 1'b0;
        #3;
    endtask

    task automatic shift_in(input vec_t v);
        logic [255:0] d;
        d = {v.ct, v.key};
        for (int i = 0; i < v.extra; i++) begin
            sck_pulse(i[0]);
        end
        for (int i = 255; i >= 0; i--) begin
            sck_pulse(d[i]);
        end
    endtask

    // Drop load just after a clk edge: latch lands on the 3rd edge,
    // done registers 22 edges later, i.e. on the 25th edge.
    task automatic load_and_start(input vec_t v);
        load = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_bit("done_low_on_load", done, 1'b0);
        shift_in(v);
        repeat (4) @(posedge clk);
        #1 load = 1'b0;
        repeat (24) @(posedge clk);
        #1 check_bit("latency_early", done, 1'b0);
        @(posedge clk);
        #1 check_bit("latency_done", done, 1'b1);
    endtask

    task automatic read_out(input logic [127:0] pt);
        logic [127:0] got;
        int           unstable;
        unstable = 0;
        got      = '0;
        check_bit("sdo_before_sck", sdo, pt[127]);
        for (int i = 127; i >= 0; i--) begin
            sdi = 1'b0;
            #3 sck = 1'b1;
            #1 got[i] = sdo;
            #3 if (sdo !== got[i]) unstable++;
            sck = 1'b0;
            #3;
        end
        check_vec("plaintext", got, pt);
        check_bit("sdo_stable_high", (unstable != 0), 1'b0);
        check_bit("sdo_after_128", sdo, 1'b0);
        sck_pulse(1'b0);
        check_bit("sdo_after_129", sdo, 1'b0);
    endtask

    initial begin
        vec_t v;
        int   seen;

        vecs[0] = '{key: 128'h2B7E151628AED2A6ABF7158809CF4F3C,
                    ct:  128'h3925841D02DC09FBDC118597196A0B32,
                    pt:  128'h3243F6A8885A308D313198A2E0370734, extra: 0};
        vecs[1] = '{key: 128'h000102030405060708090A0B0C0D0E0F,
                    ct:  128'h69C4E0D86A7B0430D8CDB78070B4C55A,
                    pt:  128'h00112233445566778899AABBCCDDEEFF, extra: 0};
        vecs[2] = '{key: 128'h2B7E151628AED2A6ABF7158809CF4F3C,
                    ct:  128'h3AD77BB40D7A3660A89ECAF32466EF97,
                    pt:  128'h6BC1BEE22E409F96E93D7E117393172A, extra: 17};
        vecs[3] = '{key: 128'h00000000000000000000000000000000,
                    ct:  128'h66E94BD4EF8A2C3B884CFA59CA342B2E,
                    pt:  128'h00000000000000000000000000000000, extra: 3};

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_bit("reset_done", done, 1'b0);
        check_bit("reset_sdo", sdo, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Back-to-back table vectors, no reset in between
        for (int i = 0; i < 4; i++) begin
            load_and_start(vecs[i]);
            read_out(vecs[i].pt);
        end

        // Reset in the middle of ROUNDS
        load = 1'b1;
        repeat (5) @(posedge clk);
        shift_in(vecs[1]);
        repeat (4) @(posedge clk);
        #1 load = 1'b0;
        repeat (18) @(posedge clk);
        #1 reset = 1'b0;
        #1 check_bit("rst_rounds_done", done, 1'b0);
        check_bit("rst_rounds_sdo", sdo, 1'b0);
        #2 reset = 1'b1;
        load_and_start(vecs[0]);
        read_out(vecs[0].pt);

        // Reset while plaintext is being presented
        load_and_start(vecs[0]);
        sck_pulse(1'b0);
        sck_pulse(1'b0);
        check_bit("sdo_bit125", sdo, 1'b1);
        reset = 1'b0;
        #1 check_bit("rst_done_state_done", done, 1'b0);
        check_bit("rst_done_state_sdo", sdo, 1'b0);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Abort during key expansion, then a complete transaction
        load = 1'b1;
        repeat (5) @(posedge clk);
        shift_in(vecs[1]);
        repeat (4) @(posedge clk);
        #1 load = 1'b0;
        repeat (8) @(posedge clk);
        #1 load = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done !== 1'b0) seen++;
        end
        check_bit("abort_done_low", (seen != 0), 1'b0);
        v = vecs[2];
        load_and_start(v);
        read_out(v.pt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/invaes.md
Name: invaes

Overview:
- AES-128 decryption accelerator behind a load-framed SPI-style serial link.
- Host shifts in 128-bit ciphertext then 128-bit key, drops load, waits for done, then shifts out 128-bit plaintext.
- Iterative core: one AES round per clk. Used as a standalone decrypt peripheral beside a host MCU.

Parameters:
- None. Fixed at AES-128: Nk=4, Nr=10.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- sck  in  1  serial clock, independent of clk.
- sdi  in  1  serial data in; sampled on sck rising edge.
- load  in  1  high while host shifts operands in; falling edge starts decryption.
- sdo  out  1  serial plaintext out, MSB first.
- done  out  1  plaintext valid and ready to shift out.

Behaviour:
- Reset (reset=0, async): core FSM to IDLE; done=0; sdo=0; round counter, state and key registers cleared. Serial shift registers also cleared.
- Input shift:
  - 256-bit register, updated on posedge sck while load=1: shift left, sdi into LSB.
  - After 256 clocks: bits[255:128] = ciphertext, bits[127:0] = key. Both MSB first; byte 0 of each block is bits [127:120].
  - sck edges with load=1 beyond 256 keep shifting; the last 256 bits win.
- Core FSM, all on posedge clk:
  - IDLE: done=0 while load=1. At the first clk edge seeing load=0 after load was high, latch ciphertext/key and go to KEYEXP.
  - KEYEXP: 10 cycles of forward key expansion (SubWord, RotWord, Rcon 01,02,04,08,10,20,40,80,1B,36), yielding round key 10.
  - INIT: one cycle, state = ciphertext XOR rk10.
  - ROUNDS: 10 cycles for r = 9..0, each InvShiftRows, InvSubBytes, AddRoundKey(rk_r), then InvMixColumns except when r=0.
    - rk_r is derived from rk_(r+1) by the inverse key step in the same cycle: w[i] ^= w[i-1] for i=3..1, then w0 ^= SubWord(RotWord(w3)) ^ Rcon(r+1).
  - DONE: done=1 and plaintext held until load rises again, then return to IDLE. done registers exactly 22 clk edges after the latching edge.
  - load rising during KEYEXP/INIT/ROUNDS aborts to IDLE with done=0.
- Output:
  - 128-bit output shift register loaded with plaintext when done rises; sdo shows plaintext[127] immediately.
  - On each posedge sck while done=1, the register advances internally. sdo updates only on the following negedge sck, so sdo is stable while sck is high.
  - After 128 sck pulses the LSB has been presented; further pulses shift in 0.
- sck/clk crossing: load and done are quasi-static during transfers. Synchronise load into clk with 2 flops. Host waits at least 3 clk cycles after the last sck before dropping load.

Optional Feature:
- Macro INVAES_KEYSTORE_EN.
- Defined: KEYEXP writes all 11 round keys into an 11x128 register file, and ROUNDS reads rk_r from it. No inverse key step logic.
- Undefined: on-the-fly inverse key schedule as above.
- Identical external timing and results either way.

Decomposition:
- Package aes_pkg:
  - state_t (4x4 bytes, column-major) and word_t;
  - Rcon constant array;
  - sbox and inv_sbox functions (256-entry case);
  - xtime/gmul helper;
  - NR=10.
- Sub-module aes_key_step: combinational forward/inverse single-round key step selected by a dir input, used by both KEYEXP and ROUNDS.
- Inverse round datapath stays inline.

Test Plan:
- FIPS-197 B: key 2B7E151628AED2A6ABF7158809CF4F3C, ct 3925841D02DC09FBDC118597196A0B32 -> plaintext 3243F6A8885A308D313198A2E0370734, done 22 clk after latch.
- FIPS-197 C.1: key 000102030405060708090A0B0C0D0E0F, ct 69C4E0D86A7B0430D8CDB78070B4C55A -> 00112233445566778899AABBCCDDEEFF.
- Serial timing: sample sdo 1 ns after each sck rise -> first sample is bit 127; no skipped or duplicated bit across all 128.
- Back-to-back: B vector then C.1 vector without reset -> both correct; done drops when load rises.
- Reset asserted mid-ROUNDS -> done=0, sdo=0 immediately; next full transaction decrypts correctly.
- load re-raised during KEYEXP -> abort, done stays 0; a subsequent complete load yields the correct plaintext.
